// File: rtl/omsp_spm_key_loader.sv
// Sancus SPM key loader: packs a key byte stream (MSB first) into 16-bit words and
// writes them, most significant word first, into the selected SPM key storage.
module omsp_spm_key_loader #(
    parameter int unsigned SECURITY     = 64,
    parameter int unsigned KEY_IDX_SIZE = 2
) (
    input  logic                    mclk,
    input  logic                    puc_rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    spm_key_select_valid,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    byte_ready,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int unsigned NWORDS = SECURITY / 16;
    localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(NWORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHi,
        StLo,
        StWrite,
        StDone
    } state_e;

    state_e                  state_q;
    logic [KEY_IDX_SIZE-1:0] word_cnt_q;
    logic [KEY_IDX_SIZE-1:0] key_idx_q;
    logic [15:0]             key_q;
    logic                    byte_ready_q;
    logic                    write_key_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic                    byte_hs;

    // A violation must stop both the byte handshake and the key write in the same cycle.
    assign byte_ready = byte_ready_q & ~abort;
    assign write_key  = write_key_q & ~abort;
    assign byte_hs    = byte_valid & byte_ready;

    assign key_in  = key_q;
    assign key_idx = key_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q      <= StIdle;
            word_cnt_q   <= '0;
            key_idx_q    <= '0;
            key_q        <= '0;
            byte_ready_q <= 1'b0;
            write_key_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            write_key_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            if (abort && (state_q != StIdle)) begin
                state_q      <= StIdle;
                byte_ready_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            if (spm_key_select_valid) begin
                                state_q      <= StHi;
                                word_cnt_q   <= '0;
                                byte_ready_q <= 1'b1;
                                busy_q       <= 1'b1;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end
                    end
                    StHi: begin
                        if (byte_hs) begin
                            key_q[15:8] <= byte_data;
                            state_q     <= StLo;
                        end
                    end
                    StLo: begin
                        if (byte_hs) begin
                            key_q[7:0]   <= byte_data;
                            key_idx_q    <= word_cnt_q;
                            byte_ready_q <= 1'b0;
                            write_key_q  <= 1'b1;
                            state_q      <= StWrite;
                        end
                    end
                    StWrite: begin
                        if (word_cnt_q == LAST_IDX) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            word_cnt_q   <= word_cnt_q + 1'b1;
                            byte_ready_q <= 1'b1;
                            state_q      <= StHi;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q      <= StIdle;
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_omsp_spm_key_loader.sv
// Scoreboard bench for omsp_spm_key_loader: directed loads with hand-computed write/done/error
// events and cycle numbers; a negedge monitor compares every DUT event against the queue.
module tb_omsp_spm_key_loader;

    localparam int unsigned SECURITY     = 64;
    localparam int unsigned KEY_IDX_SIZE = 2;
    localparam int EV_WRITE = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERROR = 2;

    typedef struct {
        int kind;
        int idx;
        int data;
        int cyc;
    } ev_t;

    logic                    mclk = 1'b0;
    logic                    puc_rst_n;
    logic                    start;
    logic                    abort;
    logic                    spm_key_select_valid;
    logic                    byte_valid;
    logic [7:0]              byte_data;
    logic                    byte_ready;
    logic                    write_key;
    logic [15:0]             key_in;
    logic [KEY_IDX_SIZE-1:0] key_idx;
    logic                    busy;
    logic                    done;
    logic                    error;

    int         n_checks = 0;
    int         n_errors = 0;
    int         edges = 0;
    ev_t        exp_q[$];
    logic [7:0] tx_q[$];
    int         stall = 0;
    int         stall_on = -1;
    int         base;

    omsp_spm_key_loader #(
        .SECURITY    (SECURITY),
        .KEY_IDX_SIZE(KEY_IDX_SIZE)
    ) dut (
        .mclk                (mclk),
        .puc_rst_n           (puc_rst_n),
        .start               (start),
        .abort               (abort),
        .spm_key_select_valid(spm_key_select_valid),
        .byte_valid          (byte_valid),
        .byte_data           (byte_data),
        .byte_ready          (byte_ready),
        .write_key           (write_key),
        .key_in              (key_in),
        .key_idx             (key_idx),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) edges++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: every write/done/error the DUT presents must match the queue head.
    always @(negedge mclk) begin
        ev_t a;
        ev_t e;
        if (puc_rst_n && (write_key || done || error)) begin
            a.kind = write_key ? EV_WRITE : (done ? EV_DONE : EV_ERROR);
            a.idx  = write_key ? int'(key_idx) : 0;
            a.data = write_key ? int'(key_in) : 0;
            a.cyc  = edges;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_event: got kind=%0d idx=%0d data=%h cyc=%0d, want none",
                         a.kind, a.idx, a.data, a.cyc);
            end else begin
                e = exp_q.pop_front();
                if (a.kind != e.kind || a.idx != e.idx || a.data != e.data || a.cyc != e.cyc) begin
                    n_errors++;
                    $display("FAIL event: got kind=%0d idx=%0d data=%h cyc=%0d, want kind=%0d idx=%0d data=%h cyc=%0d",
                             a.kind, a.idx, a.data, a.cyc, e.kind, e.idx, e.data, e.cyc);
                end
            end
        end
    end

    task automatic push_ev(input int kind, input int idx, input int data, input int cyc);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.data = data;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic refresh_bytes();
        if (stall > 0) begin
            byte_valid = 1'b0;
            stall--;
        end else if (tx_q.size() > 0) begin
            byte_valid = 1'b1;
            byte_data  = tx_q[0];
        end else begin
            byte_valid = 1'b0;
        end
    endtask

    // One clock: sample the handshake mid-cycle, then advance inputs just after the edge.
    task automatic step();
        logic       hs;
        logic [7:0] last;
        @(negedge mclk);
        hs = byte_valid && byte_ready;
        @(posedge mclk);
        #1;
        start = 1'b0;
        if (hs && tx_q.size() > 0) begin
            last = tx_q.pop_front();
            if (int'(last) == stall_on) stall = 5;
        end
        refresh_bytes();
    endtask

    // Queue key bytes first..first+7 and raise start; b returns the cycle-0 edge count.
    task automatic begin_load(input int first, output int b);
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(8'(first + i));
        refresh_bytes();
        start = 1'b1;
        b = edges;
    endtask

    function automatic int word(input int first, input int i);
        return (((first + 2 * i) & 8'hff) << 8) | ((first + 2 * i + 1) & 8'hff);
    endfunction

    task automatic push_full(input int b, input int first, input int w0, input int w1,
                             input int w2, input int w3, input int dn);
        push_ev(EV_WRITE, 0, word(first, 0), b + w0);
        push_ev(EV_WRITE, 1, word(first, 1), b + w1);
        push_ev(EV_WRITE, 2, word(first, 2), b + w2);
        push_ev(EV_WRITE, 3, word(first, 3), b + w3);
        push_ev(EV_DONE, 0, 0, b + dn);
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_byte_ready"}, int'(byte_ready), 0);
        check({tag, "_write_key"}, int'(write_key), 0);
        check({tag, "_key_in"}, int'(key_in), 0);
        check({tag, "_key_idx"}, int'(key_idx), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_error"}, int'(error), 0);
    endtask

    initial begin
        puc_rst_n            = 1'b0;
        start                = 1'b0;
        abort                = 1'b0;
        spm_key_select_valid = 1'b1;
        byte_valid           = 1'b0;
        byte_data            = 8'h00;

        repeat (2) @(posedge mclk);
        @(negedge mclk);
        check_all_reset("reset");
        @(posedge mclk);
        #1;
        puc_rst_n = 1'b1;
        step();

        // Nominal load, byte_valid always high
        begin_load(8'h01, base);
        push_full(base, 8'h01, 3, 6, 9, 12, 13);
        repeat (14) step();
        @(negedge mclk);
        check("nominal_idle_busy", int'(busy), 0);
        check("nominal_idle_ready", int'(byte_ready), 0);
        @(posedge mclk);
        #1;

        // Reset asserted while in LO
        begin_load(8'h11, base);
        repeat (2) step();
        puc_rst_n = 1'b0;
        tx_q.delete();
        refresh_bytes();
        #2;
        check_all_reset("midload_reset");
        @(posedge mclk);
        #1;
        puc_rst_n = 1'b1;
        repeat (6) step();

        // Backpressure: 5 idle cycles between bytes 0x23 and 0x24
        stall_on = 8'h23;
        begin_load(8'h21, base);
        push_full(base, 8'h21, 3, 11, 14, 17, 18);
        repeat (19) step();
        stall_on = -1;

        // Start with no SPM selected
        spm_key_select_valid = 1'b0;
        start = 1'b1;
        base  = edges;
        push_ev(EV_ERROR, 0, 0, base + 1);
        step();
        @(negedge mclk);
        check("invalid_busy_c1", int'(busy), 0);
        check("invalid_ready_c1", int'(byte_ready), 0);
        @(posedge mclk);
        #1;
        @(negedge mclk);
        check("invalid_busy_c2", int'(busy), 0);
        check("invalid_ready_c2", int'(byte_ready), 0);
        @(posedge mclk);
        #1;
        spm_key_select_valid = 1'b1;

        // Abort during WRITE of idx2, then a clean reload
        begin_load(8'h31, base);
        push_ev(EV_WRITE, 0, word(8'h31, 0), base + 3);
        push_ev(EV_WRITE, 1, word(8'h31, 1), base + 6);
        repeat (9) step();
        abort = 1'b1;
        @(negedge mclk);
        check("abort_write_masked", int'(write_key), 0);
        check("abort_ready_masked", int'(byte_ready), 0);
        @(posedge mclk);
        #1;
        abort = 1'b0;
        tx_q.delete();
        refresh_bytes();
        @(negedge mclk);
        check("abort_idle_busy", int'(busy), 0);
        @(posedge mclk);
        #1;
        begin_load(8'h41, base);
        push_full(base, 8'h41, 3, 6, 9, 12, 13);
        repeat (15) step();

        // Second start during HI of idx1 is ignored
        begin_load(8'h51, base);
        push_full(base, 8'h51, 3, 6, 9, 12, 13);
        repeat (4) step();
        start = 1'b1;
        repeat (12) step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
